// File: rtl/screen_pkg.sv
// Shared types and constants for the Pong screen scheduler: display modes,
// the pending-request record and the default menu button boxes.
package screen_pkg;

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    GAME    = 2'd1,
    CREDITS = 2'd2
  } mode_t;

  typedef struct packed {
    logic  valid;
    mode_t target;
  } pending_t;

  localparam int RGB_W = 12;

  localparam int DEF_BTN_X_MIN   = 362;
  localparam int DEF_BTN_X_MAX   = 674;
  localparam int DEF_START_Y_MIN = 46;
  localparam int DEF_START_Y_MAX = 146;
  localparam int DEF_CRED_Y_MIN  = 622;
  localparam int DEF_CRED_Y_MAX  = 722;

  // Renderer enables as {menu, game, credits}; anything unexpected shows the menu
  function automatic logic [2:0] mode_enables(input mode_t m);
    case (m)
      GAME:    return 3'b010;
      CREDITS: return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/click_decode.sv
// Mouse click front end: button edge detection, post-commit lockout and the
// hit-test of left clicks against the START and CREDITS boxes.
module click_decode
  import screen_pkg::*;
#(
  parameter int BTN_X_MIN   = DEF_BTN_X_MIN,
  parameter int BTN_X_MAX   = DEF_BTN_X_MAX,
  parameter int START_Y_MIN = DEF_START_Y_MIN,
  parameter int START_Y_MAX = DEF_START_Y_MAX,
  parameter int CRED_Y_MIN  = DEF_CRED_Y_MIN,
  parameter int CRED_Y_MAX  = DEF_CRED_Y_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic        commit,
  input  logic        credits_mode,
  output logic        start_hit,
  output logic        cred_hit,
  output logic        back_hit
);

  localparam logic [11:0] X_MIN  = 12'(BTN_X_MIN);
  localparam logic [11:0] X_MAX  = 12'(BTN_X_MAX);
  localparam logic [11:0] SY_MIN = 12'(START_Y_MIN);
  localparam logic [11:0] SY_MAX = 12'(START_Y_MAX);
  localparam logic [11:0] CY_MIN = 12'(CRED_Y_MIN);
  localparam logic [11:0] CY_MAX = 12'(CRED_Y_MAX);

  logic left_prev;
  logic right_prev;
  logic lockout;
  logic lclick;
  logic rclick;
  logic in_x;

  // A held button must not re-trigger after a mode switch, so lockout only
  // drops once both buttons have been seen released together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_prev  <= 1'b0;
      right_prev <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      left_prev  <= mouse_left;
      right_prev <= mouse_right;
      if (commit)
        lockout <= 1'b1;
      else if (!mouse_left && !mouse_right)
        lockout <= 1'b0;
    end
  end

  assign lclick = mouse_left  & ~left_prev  & ~lockout;
  assign rclick = mouse_right & ~right_prev & ~lockout;
  assign in_x   = (xpos >= X_MIN) && (xpos <= X_MAX);

  assign start_hit = lclick && in_x && (ypos >= SY_MIN) && (ypos <= SY_MAX);
  assign cred_hit  = lclick && in_x && (ypos >= CY_MIN) && (ypos <= CY_MAX);
  assign back_hit  = rclick || (credits_mode && lclick);

endmodule

// File: rtl/screen_sched.sv
// Pong screen scheduler: owns the MENU/GAME/CREDITS mode, commits mode changes
// at the start of vertical blank and drives the registered VGA output.
module screen_sched
  import screen_pkg::*;
#(
  parameter int BTN_X_MIN      = DEF_BTN_X_MIN,
  parameter int BTN_X_MAX      = DEF_BTN_X_MAX,
  parameter int START_Y_MIN    = DEF_START_Y_MIN,
  parameter int START_Y_MAX    = DEF_START_Y_MAX,
  parameter int CRED_Y_MIN     = DEF_CRED_Y_MIN,
  parameter int CRED_Y_MAX     = DEF_CRED_Y_MAX,
  parameter int CREDITS_FRAMES = 600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      vcount_in,
  input  logic [10:0]      hcount_in,
  input  logic             vsync_in,
  input  logic             hsync_in,
  input  logic             vblnk_in,
  input  logic             hblnk_in,
  input  logic [11:0]      xpos,
  input  logic [11:0]      ypos,
  input  logic             mouse_left,
  input  logic             mouse_right,
  input  logic             game_over,
  input  logic [RGB_W-1:0] rgb_menu,
  input  logic [RGB_W-1:0] rgb_game,
  input  logic [RGB_W-1:0] rgb_credits,
  output logic [10:0]      vcount_out,
  output logic [10:0]      hcount_out,
  output logic             vsync_out,
  output logic             hsync_out,
  output logic             vblnk_out,
  output logic             hblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             menu_en,
  output logic             game_en,
  output logic             credits_en,
  output logic             game_restart
);

  localparam logic [9:0] FRAMES_LIMIT = 10'(CREDITS_FRAMES);

  mode_t            mode;
  pending_t         pending;
  pending_t         request;
  logic [9:0]       frame_cnt;
  logic             vblnk_prev;
  logic             vblnk_rise;
  logic             commit;
  logic             start_hit;
  logic             cred_hit;
  logic             back_hit;
  logic [RGB_W-1:0] rgb_sel;

  assign vblnk_rise = vblnk_in & ~vblnk_prev;
  assign commit     = vblnk_rise & pending.valid;

  click_decode #(
    .BTN_X_MIN  (BTN_X_MIN),
    .BTN_X_MAX  (BTN_X_MAX),
    .START_Y_MIN(START_Y_MIN),
    .START_Y_MAX(START_Y_MAX),
    .CRED_Y_MIN (CRED_Y_MIN),
    .CRED_Y_MAX (CRED_Y_MAX)
  ) u_click (
    .clk         (clk),
    .rst         (rst),
    .xpos        (xpos),
    .ypos        (ypos),
    .mouse_left  (mouse_left),
    .mouse_right (mouse_right),
    .commit      (commit),
    .credits_mode(mode == CREDITS),
    .start_hit   (start_hit),
    .cred_hit    (cred_hit),
    .back_hit    (back_hit)
  );

  // Game over and a right click both lead back to the menu, so their
  // coincidence needs no extra arbitration; an illegal mode keeps asking for MENU.
  always_comb begin
    request = '{valid: 1'b0, target: MENU};
    case (mode)
      MENU: begin
        if (start_hit)
          request = '{valid: 1'b1, target: GAME};
        else if (cred_hit)
          request = '{valid: 1'b1, target: CREDITS};
      end
      GAME: begin
        if (game_over || back_hit)
          request = '{valid: 1'b1, target: MENU};
      end
      CREDITS: begin
        if (back_hit || (frame_cnt == FRAMES_LIMIT))
          request = '{valid: 1'b1, target: MENU};
      end
      default: request = '{valid: 1'b1, target: MENU};
    endcase
  end

  always_comb begin
    case (mode)
      GAME:    rgb_sel = rgb_game;
      CREDITS: rgb_sel = rgb_credits;
      default: rgb_sel = rgb_menu;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode         <= MENU;
      pending      <= '{valid: 1'b0, target: MENU};
      frame_cnt    <= '0;
      vblnk_prev   <= 1'b0;
      menu_en      <= 1'b1;
      game_en      <= 1'b0;
      credits_en   <= 1'b0;
      game_restart <= 1'b0;
      vcount_out   <= '0;
      hcount_out   <= '0;
      vsync_out    <= 1'b0;
      hsync_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      rgb_out      <= '0;
    end else begin
      vblnk_prev   <= vblnk_in;
      game_restart <= 1'b0;
      if (commit) begin
        mode                             <= pending.target;
        {menu_en, game_en, credits_en}   <= mode_enables(pending.target);
        game_restart                     <= (pending.target == GAME);
        pending                          <= '{valid: 1'b0, target: MENU};
        frame_cnt                        <= '0;
      end else begin
        if (request.valid)
          pending <= request;
        if (vblnk_rise && (mode == CREDITS) && (frame_cnt != FRAMES_LIMIT))
          frame_cnt <= frame_cnt + 10'd1;
      end
      vcount_out <= vcount_in;
      hcount_out <= hcount_in;
      vsync_out  <= vsync_in;
      hsync_out  <= hsync_in;
      vblnk_out  <= vblnk_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= (hblnk_in || vblnk_in) ? '0 : rgb_sel;
    end
  end

endmodule

// File: tb/tb_screen_sched.sv
// Directed bench for screen_sched: a vector table for the output pipeline plus
// hand-written sequences for clicks, vblank commits, lockout and reset.
module tb_screen_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0] xpos, ypos;
  logic        mouse_left, mouse_right, game_over;
  logic [11:0] rgb_menu, rgb_game, rgb_credits;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
  logic        menu_en, game_en, credits_en, game_restart;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [11:0] menu_px;
    logic [11:0] game_px;
    logic [11:0] cred_px;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  screen_sched #(.CREDITS_FRAMES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .vcount_in   (vcount_in),
    .hcount_in   (hcount_in),
    .vsync_in    (vsync_in),
    .hsync_in    (hsync_in),
    .vblnk_in    (vblnk_in),
    .hblnk_in    (hblnk_in),
    .xpos        (xpos),
    .ypos        (ypos),
    .mouse_left  (mouse_left),
    .mouse_right (mouse_right),
    .game_over   (game_over),
    .rgb_menu    (rgb_menu),
    .rgb_game    (rgb_game),
    .rgb_credits (rgb_credits),
    .vcount_out  (vcount_out),
    .hcount_out  (hcount_out),
    .vsync_out   (vsync_out),
    .hsync_out   (hsync_out),
    .vblnk_out   (vblnk_out),
    .hblnk_out   (hblnk_out),
    .rgb_out     (rgb_out),
    .menu_en     (menu_en),
    .game_en     (game_en),
    .credits_en  (credits_en),
    .game_restart(game_restart)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_enables(input string name, input logic [2:0] expected);
    check_output(name, {29'd0, menu_en, game_en, credits_en}, {29'd0, expected});
  endtask

  task automatic apply_stimulus(input vec_t v);
    hblnk_in    = v.hblnk;
    vblnk_in    = v.vblnk;
    hsync_in    = v.hsync;
    vsync_in    = v.vsync;
    hcount_in   = v.hcount;
    vcount_in   = v.vcount;
    rgb_menu    = v.menu_px;
    rgb_game    = v.game_px;
    rgb_credits = v.cred_px;
  endtask

  task automatic click_left(input logic [11:0] x, input logic [11:0] y);
    xpos = x;
    ypos = y;
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
    tick();
  endtask

  task automatic click_right();
    mouse_right = 1'b1;
    tick();
    mouse_right = 1'b0;
    tick();
    tick();
  endtask

  task automatic vblank_rise();
    vblnk_in = 1'b1;
    tick();
  endtask

  task automatic vblank_fall();
    tick();
    vblnk_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd100, 11'd10,  12'hABC, 12'h123, 12'h456, 12'hABC};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd101, 11'd10,  12'h0F0, 12'h123, 12'h456, 12'h0F0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 11'd650, 11'd10,  12'hABC, 12'h123, 12'h456, 12'h000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'd700, 11'd10,  12'hABC, 12'h123, 12'h456, 12'h000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 11'd0,   11'd600, 12'hABC, 12'h123, 12'h456, 12'h000};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 11'd800, 11'd601, 12'hFFF, 12'h123, 12'h456, 12'h000};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd0,   11'd0,   12'hFFF, 12'h123, 12'h456, 12'hFFF};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd1,   11'd0,   12'h001, 12'hFFF, 12'hFFF, 12'h001};

    rst = 1'b1;
    vcount_in = 11'd7;  hcount_in = 11'd5;
    vsync_in = 1'b1;    hsync_in = 1'b1;
    vblnk_in = 1'b0;    hblnk_in = 1'b0;
    xpos = 12'd0;       ypos = 12'd0;
    mouse_left = 1'b0;  mouse_right = 1'b0;  game_over = 1'b0;
    rgb_menu = 12'hABC; rgb_game = 12'h123;  rgb_credits = 12'h456;

    // Asynchronous reset, checked before any clock edge and again while held
    #2 rst = 1'b0;
    #1;
    check_enables("reset_enables", 3'b100);
    check_output("reset_restart", game_restart, 1'b0);
    check_output("reset_rgb", rgb_out, 12'h000);
    check_output("reset_timing", {hcount_out, vcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}, 26'd0);
    tick();
    check_output("reset_held_rgb", rgb_out, 12'h000);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      if (i > 0) begin
        #1;
        check_output("latency_hold_rgb", rgb_out, vecs[i-1].exp_rgb);
      end
      tick();
      check_output("vec_rgb", rgb_out, vecs[i].exp_rgb);
      check_output("vec_hcount", hcount_out, vecs[i].hcount);
      check_output("vec_vcount", vcount_out, vecs[i].vcount);
      check_output("vec_strobes", {hblnk_out, vblnk_out, hsync_out, vsync_out},
                   {vecs[i].hblnk, vecs[i].vblnk, vecs[i].hsync, vecs[i].vsync});
      check_enables("vec_enables", 3'b100);
    end

    hblnk_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    hcount_in = 11'd300; vcount_in = 11'd200;
    rgb_menu = 12'hABC; rgb_game = 12'h123; rgb_credits = 12'h456;
    tick();
    tick();

    // Clicks outside the buttons (including one pixel left of the box) are ignored
    click_left(12'd500, 12'd400);
    for (int f = 0; f < 3; f++) begin
      vblank_rise();
      check_enables("outside_click_menu", 3'b100);
      vblank_fall();
    end
    click_left(12'd361, 12'd100);
    vblank_rise();
    check_enables("x_edge_outside_menu", 3'b100);
    vblank_fall();

    // CREDITS via the box corner, then automatic return on the fourth vblank
    click_left(12'd362, 12'd722);
    check_enables("credits_wait_vblank", 3'b100);
    vblank_rise();
    check_enables("credits_entered", 3'b001);
    check_output("credits_no_restart", game_restart, 1'b0);
    vblank_fall();
    check_output("credits_rgb", rgb_out, 12'h456);
    for (int f = 1; f <= 3; f++) begin
      vblank_rise();
      check_enables("credits_counting", 3'b001);
      vblank_fall();
    end
    vblank_rise();
    check_enables("credits_auto_return", 3'b100);
    vblank_fall();
    check_output("menu_rgb_after_credits", rgb_out, 12'hABC);

    // START held through the commit; a right click while still held is locked out
    xpos = 12'd500;
    ypos = 12'd100;
    mouse_left = 1'b1;
    tick();
    tick();
    check_enables("start_mid_frame", 3'b100);
    check_output("start_mid_frame_rgb", rgb_out, 12'hABC);
    vblank_rise();
    check_enables("game_entered", 3'b010);
    check_output("game_restart_pulse", game_restart, 1'b1);
    vblank_fall();
    check_output("game_restart_single", game_restart, 1'b0);
    check_output("game_rgb", rgb_out, 12'h123);
    mouse_right = 1'b1;
    tick();
    tick();
    mouse_right = 1'b0;
    tick();
    vblank_rise();
    check_enables("lockout_ignored", 3'b010);
    vblank_fall();
    mouse_left = 1'b0;
    tick();
    tick();
    click_right();
    vblank_rise();
    check_enables("rclick_back_menu", 3'b100);
    check_output("menu_no_restart", game_restart, 1'b0);
    vblank_fall();

    // A click on the vblank edge itself waits for the following frame
    xpos = 12'd500;
    ypos = 12'd100;
    vblnk_in = 1'b1;
    mouse_left = 1'b1;
    tick();
    check_enables("same_edge_wait", 3'b100);
    mouse_left = 1'b0;
    vblank_fall();
    vblank_rise();
    check_enables("same_edge_next_frame", 3'b010);
    check_output("same_edge_restart", game_restart, 1'b1);
    vblank_fall();

    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    tick();
    vblank_rise();
    check_enables("game_over_menu", 3'b100);
    vblank_fall();
    click_left(12'd674, 12'd46);
    vblank_rise();
    check_enables("start_corner_game", 3'b010);
    vblank_fall();

    // Reset mid-frame in GAME with a pending request
    click_right();
    rst = 1'b0;
    #1;
    check_enables("midreset_enables", 3'b100);
    check_output("midreset_rgb", rgb_out, 12'h000);
    check_output("midreset_hcount", hcount_out, 11'd0);
    check_output("midreset_restart", game_restart, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_output("after_reset_rgb", rgb_out, 12'hABC);
    vblank_rise();
    check_enables("after_reset_menu", 3'b100);
    check_output("after_reset_restart", game_restart, 1'b0);
    vblank_fall();

    // A pending START must be dropped by reset
    click_left(12'd500, 12'd100);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vblank_rise();
    check_enables("pending_dropped", 3'b100);
    check_output("pending_dropped_restart", game_restart, 1'b0);
    vblank_fall();
    vblank_rise();
    check_enables("pending_dropped_next", 3'b100);
    vblank_fall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_sched.md
# screen_sched

Top-level screen scheduler for the Pong display pipeline. It owns the MENU/GAME/CREDITS mode state and decodes mouse clicks against the menu button boxes. Mode changes are committed only at the start of vertical blank, so no frame is torn. It also gives the single registered VGA output port to exactly one of three renderers (menu, game, credits) and sequences their enables and the game restart pulse.

## Interface
Parameters:
- BTN_X_MIN, 362, left edge of both menu buttons (inclusive)
- BTN_X_MAX, 674, right edge of both menu buttons (inclusive)
- START_Y_MIN / START_Y_MAX, 46 / 146, START button vertical span (inclusive)
- CRED_Y_MIN / CRED_Y_MAX, 622 / 722, CREDITS button vertical span (inclusive)
- CREDITS_FRAMES, 600, number of frames before CREDITS auto-returns to MENU (valid range 1..1023)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vcount_in, hcount_in  in  11 each  timing counters, aligned with the renderer rgb inputs
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  timing strobes, aligned with the rgb inputs
- xpos, ypos  in  12 each  mouse position
- mouse_left  in  1  left button level
- mouse_right  in  1  right button level; "back"
- game_over  in  1  one-cycle pulse from game logic
- rgb_menu, rgb_game, rgb_credits  in  12 each  renderer pixel data
- vcount_out, hcount_out  out  11 each  registered timing counters
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1 each  registered timing strobes
- rgb_out  out  12  registered selected pixel
- menu_en, game_en, credits_en  out  1 each  one-hot active-renderer enable
- game_restart  out  1  one-cycle pulse on entry to GAME

## Operation
- Modes: MENU=2'd0, GAME=2'd1, CREDITS=2'd2. Encoding 2'd3 is illegal; if reached, the block forces MENU at the next commit.
- Click detection:
  - lclick = mouse_left rising edge (registered previous level); rclick likewise for mouse_right.
  - After any commit, clicks are locked out until mouse_left and mouse_right are both low for at least one cycle.
- Request generation (current mode → pending request):
  - MENU: lclick inside START box → GAME; lclick inside CREDITS box → CREDITS; a click outside both boxes is ignored.
  - GAME: rclick or game_over → MENU.
  - CREDITS: lclick, rclick, or frame counter reaching CREDITS_FRAMES → MENU.
- Pending register: 1 valid bit plus target mode. A later request in the same frame overwrites the earlier one. If game_over and a click occur in the same cycle, game_over wins.
- Commit:
  - Occurs on a vblnk_in rising edge with pending valid.
  - mode ← target and pending is cleared. If target is GAME, game_restart pulses in the same cycle as the mode update.
  - A request raised on the same cycle as the vblnk edge waits for the next frame.
- Frame counter:
  - 10 bits. Cleared on every commit.
  - Increments on each vblnk_in rising edge while in CREDITS.
  - Saturates at CREDITS_FRAMES.
- Output mux: rgb selected by mode; rgb_out forced to 12'h000 when hblnk_in or vblnk_in is high. Timing signals pass through the same register stage.
- Enables: a decode of the current mode, one-hot at all times.

## Timing
- Reset (rst low, asynchronous):
  - mode=MENU, pending clear, lockout clear, frame counter 0.
  - menu_en=1, game_en=0, credits_en=0, game_restart=0.
  - All timing outputs 0, rgb_out=0.
- Output pipeline: latency 1 cycle from *_in/rgb_* to *_out. No bubbles.
- Click to mode change:
  - Click edge at cycle N → pending valid at N+1.
  - Commit at the first vblnk_in rising edge at cycle ≥ N+1.
  - The first cycle of the new mode drives rgb_out one cycle after the commit cycle.
- Reset deasserted mid-frame: behaves as MENU with no pending request. The first commit is possible at the next vblank.
- Enables and game_restart change on the commit clock edge, not on the click.

## Structure
- Package screen_pkg: the mode typedef/localparams (MENU, GAME, CREDITS), the 12-bit RGB width, and the default button-box constants.
- One sub-module, click_decode: edge detection, lockout, and box hit-test. It outputs start_hit, cred_hit and back_hit pulses.
- The top holds the mode/pending/frame-counter logic and the output register.

## Test plan
- Reset, then feed a frame of timing with rgb_menu=12'hABC → rgb_out=12'hABC in the active area, 0 in blanking, menu_en=1, 1-cycle latency.
- Click in START box mid-frame (xpos=500, ypos=100) → no change until the next vblnk rise. Then game_en=1, one game_restart pulse, and rgb_out follows rgb_game.
- Click in MENU at (xpos=500, ypos=400), outside both boxes → mode stays MENU through 3 frames.
- Enter CREDITS (xpos=362, ypos=722, boundary) with CREDITS_FRAMES=3 → auto-return to MENU at the 4th vblank commit.
- In GAME, hold mouse_left through the commit, then rclick without releasing mouse_left → ignored (lockout). Release both, then rclick → MENU at the next vblank.
- Assert rst low mid-frame while in GAME with a request pending → all outputs reach reset values immediately. After release: MENU, and no commit at the next vblank.
